// File: rtl/logic_reset_sequencer.sv
// logic_reset_sequencer
//   Releases DOMAINS downstream reset domains one at a time, in index order,
//   after system reset or a software request. All domains are first held in
//   reset for HOLD_CYCLES. Each released domain then gets at least DELAY cycles
//   plus its ready handshake before the next release. If ready never arrives,
//   the sequence moves on after TIMEOUT cycles and flags that domain.
//
// Ports
//   aclk            clock
//   areset          async active-high reset
//   reset_request   single-cycle request to re-run the sequence
//   domain_ready    per-domain init-complete level; only the active domain is looked at
//   domain_reset_n  per-domain active-low reset (registered)
//   current_domain  index of the domain being released
//   busy / done     sequence running / sequence complete (busy == !done)
//   timeout_error   sticky per-domain flag: advanced by timeout, not by ready
module logic_reset_sequencer #(
  parameter int DOMAINS     = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int DELAY       = 8,
  parameter int TIMEOUT     = 256,
  localparam int DW         = (DOMAINS > 1) ? $clog2(DOMAINS) : 1
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               reset_request,
  input  logic [DOMAINS-1:0] domain_ready,
  output logic [DOMAINS-1:0] domain_reset_n,
  output logic [DW-1:0]      current_domain,
  output logic               busy,
  output logic               done,
  output logic [DOMAINS-1:0] timeout_error
);

  localparam int MAXC = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]      cur_q, cur_d;
  logic [DOMAINS-1:0] rstn_q, rstn_d;
  logic [DOMAINS-1:0] err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               rdy_act;
  logic               last;
  logic               adv;
  logic [DW-1:0]      nxt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    rstn_d  = rstn_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    adv     = 1'b0;
    nxt     = cur_q + DW'(1);
    last    = (cur_q == DW'(DOMAINS - 1));

    // ready of the active domain only; the others are ignored
    rdy_act = 1'b0;
    for (int i = 0; i < DOMAINS; i++)
      if (DW'(i) == cur_q) rdy_act = domain_ready[i];

    case (state_q)
      S_HOLD: begin
        if (reset_request) begin
          cnt_d = '0;  // request during hold just stretches the hold
        end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d   = S_RELEASE;
          cnt_d     = '0;
          cur_d     = '0;
          rstn_d    = '0;
          rstn_d[0] = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RELEASE: begin
        if (!reset_request) begin
          // ready wins over timeout when both hold on the same edge
          if (cnt_q >= CW'(DELAY - 1) && rdy_act) begin
            adv = 1'b1;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            adv = 1'b1;
            for (int i = 0; i < DOMAINS; i++)
              if (DW'(i) == cur_q) err_d[i] = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end

          if (adv) begin
            cnt_d = '0;
            if (last) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              cur_d = nxt;
              for (int i = 0; i < DOMAINS; i++)
                if (DW'(i) == nxt) rstn_d[i] = 1'b1;
            end
          end
        end
      end

      default: ;
    endcase

    // abort / re-run: request overrides any advance or timeout above
    if ((state_q != S_HOLD && reset_request) ||
        (state_q != S_HOLD && state_q != S_RELEASE && state_q != S_DONE)) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      cur_d   = '0;
      rstn_d  = '0;
      err_d   = '0;
      done_d  = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      cur_q   <= '0;
      rstn_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      rstn_q  <= rstn_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign domain_reset_n = rstn_q;
  assign current_domain = cur_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout_error  = err_q;

endmodule
